nrzi_rx: RTL and testbench
==========================

# nrzi_rx

NRZI line receiver. It decodes a toggle-encoded serial line (a transition means bit 1, no transition means bit 0, the same rule as a T flip-flop driven by the data bit). It hunts for a sync word, frames the following bits into words, and hands each word out over a valid/ready handshake. It sits downstream of the T-flip-flop-based NRZI transmitter and recovers the T input stream from the Q line.

## Interface
- DATA_W, 8, word width and shift-register width
- SYNC, 8'h7E, decoded word that marks word alignment (width DATA_W)
- ABORT, 8'hFF, decoded word that drops lock (width DATA_W)
- clk  in  1  rising-edge clock, single domain
- rst_n  in  1  reset, asynchronous assert, active-low
- bit_en  in  1  one-cycle strobe: sample line_in this cycle
- line_in  in  1  NRZI line level, already synchronous to clk
- clr  in  1  synchronous restart: FSM to HUNT, clears overrun
- out_data  out  DATA_W  received word, MSB received first
- out_valid  out  1  out_data holds an undelivered word
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- locked  out  1  FSM is in LOCKED
- overrun  out  1  sticky: a word was dropped because the slot was full

## Operation
- Decode: on bit_en, dbit = line_in ^ line_prev, then line_prev <= line_in. Nothing changes when bit_en is low. line_prev resets to 0.
- Shift register sh: on bit_en, sh <= {sh[DATA_W-2:0], dbit}.
- FSM states:
  - HUNT: on bit_en, if the new sh value equals SYNC -> LOCKED and cnt <= 0.
  - LOCKED: on bit_en, cnt increments. On the DATA_W-th bit (cnt == DATA_W-1) the assembled word w is complete and cnt wraps to 0.
    - w == ABORT -> HUNT; the word is not delivered.
    - Otherwise w is offered to the output slot and the FSM stays in LOCKED.
  - A SYNC value that arrives while LOCKED is ordinary data and is delivered.
- Output slot, when w is offered:
  - Slot empty, or being emptied this cycle (out_ready high): load out_data <= w and set out_valid.
  - Otherwise drop w and set overrun. The held word is preserved.
- Handshake: out_valid clears after a cycle with out_valid && out_ready, unless a new word loads in the same cycle. out_data is stable while out_valid is high and not accepted.
- clr: state <= HUNT, cnt <= 0, sh <= 0, overrun <= 0. line_prev, out_valid and out_data are untouched. clr has priority over bit_en in the same cycle.
- Reset values: all outputs 0, state HUNT, sh 0, cnt 0, line_prev 0.
- Reset mid-word: the partial word is discarded and hunting restarts. A pending undelivered word is lost.

## Timing
- locked rises the cycle after the bit_en that completes SYNC.
- out_valid and out_data update the cycle after the bit_en carrying the last bit of a word. Latency is 1 clk from the final strobe.
- overrun sets the cycle after the dropping strobe and stays set until clr or reset.
- Back-to-back bit_en on every clk is legal; the minimum word period is DATA_W clocks.
- Accept and new-word load in the same cycle: out_valid stays 1, out_data takes the new word, and there is no overrun.

## Structure
- Shared package nrzi_pkg holds:
  - default SYNC (8'h7E) and ABORT (8'hFF) constants
  - state enum {HUNT, LOCKED}
- This package is also used by the transmitter.
- Optional sub-module nrzi_dec (line_prev register plus XOR, gated by bit_en) isolates the T-flip-flop inverse. Everything else stays in nrzi_rx.
- Counter width is $clog2(DATA_W).

## Test plan
- **Lock:** line levels 0,1,0,1,0,1,0,0 on 8 consecutive bit_en strobes from reset (decodes to 0x7E) -> locked = 1 one cycle after the 8th strobe; out_valid stays 0.
- **Data:** after lock, send 0xA5 NRZI-encoded with out_ready = 1 -> out_valid pulses for 1 cycle with out_data = 0xA5, one clk after the 8th strobe.
- **Backpressure:** out_ready = 0; send 0x3C then 0xC3 -> out_data holds 0x3C and overrun = 1. Then raise out_ready -> 0x3C accepted, out_valid = 0.
- **Simultaneous:** out_valid = 1 with 0x11; assert out_ready on the same cycle 0x22 completes -> out_data = 0x22, out_valid = 1, overrun = 0.
- **Abort/clr:** send 0xFF while locked -> locked = 0 and no out_valid. Then pulse clr -> overrun clears, and 0x7E relocks.
- **Reset:** rst_n low mid-word (4 bits in) -> all outputs 0 immediately. After release, the next 0x7E relocks and the partial bits are ignored.

Source files
------------

// File: rtl/nrzi_pkg.sv
// Shared NRZI definitions for the line transmitter and receiver.
// Holds default framing words, the receiver state type and the decode rule.
package nrzi_pkg;

    localparam logic [7:0] SYNC_DEF  = 8'h7E;
    localparam logic [7:0] ABORT_DEF = 8'hFF;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // A line transition carries a 1, a steady line carries a 0.
    function automatic logic nrzi_bit(input logic level, input logic prev);
        return level ^ prev;
    endfunction

endpackage

// File: rtl/nrzi_dec.sv
// NRZI bit decoder: inverse of the T-flip-flop transmitter.
// Remembers the previous sampled line level and emits the toggle bit.
module nrzi_dec
    import nrzi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_en_i,
    input  logic line_i,
    output logic dbit_o
);

    logic line_prev_q;

    assign dbit_o = nrzi_bit(line_i, line_prev_q);

    // Track the line level only on sample strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_prev_q <= 1'b0;
        end else if (bit_en_i) begin
            line_prev_q <= line_i;
        end
    end

endmodule

// File: rtl/nrzi_rx.sv
// NRZI receiver: decodes the line, hunts for SYNC, frames words
// and delivers them through a single-entry valid/ready slot.
module nrzi_rx
    import nrzi_pkg::*;
#(
    parameter int unsigned         DATA_W = 8,
    parameter logic [DATA_W-1:0]   SYNC   = DATA_W'(SYNC_DEF),
    parameter logic [DATA_W-1:0]   ABORT  = DATA_W'(ABORT_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              line_in,
    input  logic              clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              locked,
    output logic              overrun
);

    localparam int unsigned CNT_W =
        (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic              dbit;
    state_e            state_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              overrun_q;
    logic              accept;
    logic              slot_free;

    nrzi_dec u_dec (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_en_i (bit_en),
        .line_i   (line_in),
        .dbit_o   (dbit)
    );

    assign sh_d      = {sh_q[DATA_W-2:0], dbit};
    assign accept    = out_valid_q && out_ready;
    assign slot_free = !out_valid_q || out_ready;

    // Framing FSM, shift register and output slot in one register block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sh_q        <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b0;
            end
            if (clr) begin
                state_q   <= HUNT;
                sh_q      <= '0;
                cnt_q     <= '0;
                overrun_q <= 1'b0;
            end else if (bit_en) begin
                sh_q <= sh_d;
                unique case (state_q)
                    HUNT: begin
                        if (sh_d == SYNC) begin
                            state_q <= LOCKED;
                            cnt_q   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (sh_d == ABORT) begin
                                state_q <= HUNT;
                            end else if (slot_free) begin
                                out_data_q  <= sh_d;
                                out_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = (state_q == LOCKED);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_nrzi_rx.sv
// Bench for nrzi_rx: directed scenarios then random traffic,
// every cycle compared against a word-level reference model.
module tb_nrzi_rx;

    localparam int DW    = 8;
    localparam int SYNCW = 'h7E;
    localparam int ABRTW = 'hFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_en = 1'b0;
    logic          line_in = 1'b0;
    logic          clr = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          locked;
    logic          overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_prev, m_hist, m_nbits;
    int m_locked, m_valid, m_data, m_ovr;

    int tx_level = 0;
    int gap_pct = 0;
    bit rand_rdy = 0;

    nrzi_rx #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .line_in   (line_in),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .locked    (locked),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_hist = 0; m_nbits = 0;
        m_locked = 0; m_valid = 0; m_data = 0; m_ovr = 0;
    endtask

    // One clock of the receiver behaviour, in bit/word terms.
    task automatic model_step();
        int d;
        int nv;
        nv = (m_valid && out_ready) ? 0 : m_valid;
        d = 0;
        if (bit_en) begin
            d = int'(line_in) ^ m_prev;
            m_prev = int'(line_in);
        end
        if (clr) begin
            m_locked = 0; m_hist = 0; m_nbits = 0; m_ovr = 0;
        end else if (bit_en) begin
            m_hist = (m_hist * 2 + d) % 256;
            if (!m_locked) begin
                if (m_hist == SYNCW) begin
                    m_locked = 1;
                    m_nbits = 0;
                end
            end else begin
                m_nbits++;
                if (m_nbits == DW) begin
                    m_nbits = 0;
                    if (m_hist == ABRTW) m_locked = 0;
                    else if (!m_valid || out_ready) begin
                        m_data = m_hist;
                        nv = 1;
                    end else m_ovr = 1;
                end
            end
        end
        m_valid = nv;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("locked", 32'(locked), 32'(m_locked));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic strobe(input int level);
        while (gap_pct > 0 &&
               $urandom_range(99) < gap_pct) begin
            bit_en = 1'b0;
            if (rand_rdy) out_ready = 1'($urandom);
            tick();
        end
        line_in = 1'(level);
        bit_en = 1'b1;
        if (rand_rdy) out_ready = 1'($urandom);
        tick();
        bit_en = 1'b0;
    endtask

    task automatic send_word(input int w);
        for (int i = DW - 1; i >= 0; i--) begin
            if ((w >> i) & 1) tx_level ^= 1;
            strobe(tx_level);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_rdy) out_ready = 1'($urandom);
            tick();
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_overrun", 32'(overrun), 0);
        model_reset();
        tx_level = 0;
        line_in = 1'b0;
        bit_en = 1'b0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int lv[8];
        int r;
        lv = '{0, 1, 0, 1, 0, 1, 0, 0};
        model_reset();
        #1;
        check("rst0_valid", 32'(out_valid), 0);
        check("rst0_locked", 32'(locked), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(2);

        // lock from raw line levels
        foreach (lv[i]) strobe(lv[i]);
        tx_level = 0;
        check("lock_up", 32'(locked), 1);
        check("lock_novalid", 32'(out_valid), 0);

        // single word with consumer ready
        out_ready = 1'b1;
        send_word('hA5);
        check("data_valid", 32'(out_valid), 1);
        check("data_word", 32'(out_data), 'hA5);
        idle(1);
        check("data_pulse", 32'(out_valid), 0);

        // accept and load in the same cycle
        out_ready = 1'b0;
        send_word('h11);
        check("sim_first", 32'(out_data), 'h11);
        for (int i = DW - 1; i >= 0; i--) begin
            if (('h22 >> i) & 1) tx_level ^= 1;
            out_ready = (i == 0);
            strobe(tx_level);
        end
        check("sim_valid", 32'(out_valid), 1);
        check("sim_data", 32'(out_data), 'h22);
        check("sim_ovr", 32'(overrun), 0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;

        // backpressure drop
        send_word('h3C);
        send_word('hC3);
        check("bp_hold", 32'(out_data), 'h3C);
        check("bp_ovr", 32'(overrun), 1);
        out_ready = 1'b1;
        idle(1);
        check("bp_drain", 32'(out_valid), 0);

        // abort then clr and relock
        send_word(ABRTW);
        check("abort_unlock", 32'(locked), 0);
        check("abort_novalid", 32'(out_valid), 0);
        pulse_clr();
        check("clr_ovr", 32'(overrun), 0);
        send_word(SYNCW);
        check("relock", 32'(locked), 1);

        // reset mid-word
        send_word('h0F >> 0);
        for (int i = 0; i < 4; i++) begin
            tx_level ^= i & 1;
            strobe(tx_level);
        end
        do_reset();
        send_word(SYNCW);
        check("rst_relock", 32'(locked), 1);

        // random traffic
        gap_pct = 30;
        rand_rdy = 1;
        for (int f = 0; f < 400; f++) begin
            r = $urandom_range(99);
            if (r < 15) send_word(SYNCW);
            else if (r < 20) send_word(ABRTW);
            else if (r < 23) pulse_clr();
            else if (r < 24) do_reset();
            else if (r < 30) idle($urandom_range(6));
            else send_word($urandom_range(255));
        end
        gap_pct = 0;
        rand_rdy = 0;
        out_ready = 1'b1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
